// File: rtl/mc_control_ext_pkg.sv
// mc_control_ext_pkg: shared control_word types (FSM states, trap causes, datapath mux selects, control-word struct) and decode helpers
package mc_control_ext_pkg;
  typedef enum logic [3:0] {FETCH1, FETCH2, FETCH3, DECODE, EXEC, CALC_ADDR, LD1, LD2, ST1, ST2, MD_WAIT, TRAP} state_t;
  typedef enum logic [1:0] {TC_ILLEGAL = 2'd0, TC_MISALIGNED = 2'd1, TC_TIMEOUT = 2'd2} trap_cause_t;
  typedef enum logic [1:0] {PC_PLUS4, PC_ALU_OUT, PC_ALU_MOD2, PC_TRAP_VEC} pcmux_t;
  typedef enum logic {MAR_PC_OUT, MAR_ALU_OUT} marmux_t;
  typedef enum logic {CMP_RS2_OUT, CMP_I_IMM} cmpmux_t;
  typedef enum logic {A1_RS1_OUT, A1_PC_OUT} alumux1_t;
  typedef enum logic [2:0] {A2_I_IMM, A2_U_IMM, A2_B_IMM, A2_S_IMM, A2_J_IMM, A2_RS2_OUT} alumux2_t;
  typedef enum logic [3:0] {RF_ALU_OUT, RF_BR_EN, RF_U_IMM, RF_LW, RF_PC_PLUS4, RF_LB, RF_LBU, RF_LH, RF_LHU, RF_MULDIV_OUT} regfilemux_t;
  typedef enum logic [2:0] {ALU_ADD, ALU_SLL, ALU_SRA, ALU_SUB, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND} alu_ops_t;
  typedef enum logic [2:0] {BR_BEQ = 3'b000, BR_BNE = 3'b001, BR_BLT = 3'b100, BR_BGE = 3'b101, BR_BLTU = 3'b110, BR_BGEU = 3'b111} branch_funct3_t;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  typedef struct packed {
    logic           load_pc;
    pcmux_t         pcmux_sel;
    logic           load_ir;
    logic           load_mar;
    marmux_t        marmux_sel;
    logic           load_mdr;
    logic           load_data_out;
    logic           load_regfile;
    regfilemux_t    regfilemux_sel;
    alumux1_t       alumux1_sel;
    alumux2_t       alumux2_sel;
    alu_ops_t       aluop;
    cmpmux_t        cmpmux_sel;
    branch_funct3_t cmpop;
  } ctrl_word_t;
  function automatic logic [3:0] store_mask(input logic [1:0] sz, input logic [1:0] lsb);
    return sz[1] ? 4'b1111 : sz[0] ? 4'b0011 << lsb : 4'b0001 << lsb;
  endfunction
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lsb);
    return (sz == 2'b10 && lsb != 2'b00) || (sz == 2'b01 && lsb[0]);
  endfunction
endpackage

// File: rtl/mc_control_ext_if.sv
// mc_control_ext_if: controller/datapath bundle; master = controller (IR fields, br_en, addr_lsb, mem_resp, md_done in; ctrl, strobes, mask, md_start, trap, retire out), slave = datapath
interface mc_control_ext_if;
  import mc_control_ext_pkg::*;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       br_en;
  logic [1:0] addr_lsb;
  logic       mem_resp;
  logic       md_done;
  ctrl_word_t ctrl;
  logic       mem_read;
  logic       mem_write;
  logic [3:0] mem_byte_enable;
  logic       md_start;
  logic       trap;
  logic [1:0] trap_cause;
  logic       retire;
  modport master (input opcode, funct3, funct7, br_en, addr_lsb, mem_resp, md_done,
                  output ctrl, mem_read, mem_write, mem_byte_enable, md_start, trap, trap_cause, retire);
  modport slave (output opcode, funct3, funct7, br_en, addr_lsb, mem_resp, md_done,
                 input ctrl, mem_read, mem_write, mem_byte_enable, md_start, trap, trap_cause, retire);
endinterface

// File: rtl/mc_control_ext_mem_wait_timer.sv
// mem_wait_timer: 16-bit memory-wait counter (zero outside wait states, counts cycles without resp) flagging timeout on the last allowed cycle
module mem_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic resp,
  output logic timeout
);
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = !en ? 16'd0 : !resp ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst ? 16'd0 : cnt_d;
  assign timeout = (TIMEOUT != 0) && en && !resp && cnt_q == 16'(TIMEOUT - 1);
endmodule

// File: rtl/mc_control_ext.sv
// mc_control_ext: multicycle RV32I(+M) control FSM; clk/rst plus bus (master) carrying IR fields and handshakes in, control word, memory strobes, md_start, trap and retire out
module mc_control_ext
  import mc_control_ext_pkg::*;
#(
  parameter bit ENABLE_M    = 1'b1,
  parameter int MEM_TIMEOUT = 64,
  parameter bit TRAP_EN     = 1'b1
) (
  input logic clk,
  input logic rst,
  mc_control_ext_if.master bus
);
  state_t      state_q, state_d;
  logic [3:0]  mask_q, mask_d;
  logic        md_issued_q, md_issued_d;
  trap_cause_t cause_q, cause_d;
  ctrl_word_t  ctrl;
  logic        mem_read, mem_write, md_start, trap, retire, timeout;
  logic [3:0]  byte_en;
  trap_cause_t trap_cause;
  logic [6:0]  op;
  logic [2:0]  f3;
  logic        alt, is_m, is_store, is_slt, legal;
  alu_ops_t    arith_op;
  assign op       = bus.opcode;
  assign f3       = bus.funct3;
  assign alt      = bus.funct7 == 7'b0100000;
  assign is_m     = bus.funct7 == 7'b0000001;
  assign is_store = op == OP_STORE;
  assign is_slt   = f3[2:1] == 2'b01;
  assign legal    = op == OP_LUI || op == OP_AUIPC || op == OP_IMM || op == OP_REG || op == OP_BR || op == OP_JAL || op == OP_JALR;
  assign arith_op = is_slt ? ALU_ADD : (f3 == 3'b101 && alt) ? ALU_SRA : (f3 == 3'b000 && alt && op == OP_REG) ? ALU_SUB : alu_ops_t'(f3);
  mem_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .en     (state_q == FETCH2 || state_q == LD1 || state_q == ST1),
    .resp   (bus.mem_resp),
    .timeout(timeout)
  );
  always_comb begin
    ctrl        = '0;
    ctrl.aluop  = ALU_ADD;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    byte_en     = 4'b0000;
    md_start    = 1'b0;
    trap        = 1'b0;
    trap_cause  = TC_ILLEGAL;
    retire      = 1'b0;
    state_d     = state_q;
    mask_d      = mask_q;
    md_issued_d = md_issued_q;
    cause_d     = cause_q;
    case (state_q)
      FETCH1: begin
        ctrl.load_mar   = 1'b1;
        ctrl.marmux_sel = MAR_PC_OUT;
        state_d         = FETCH2;
      end
      FETCH2: begin
        mem_read      = 1'b1;
        ctrl.load_mdr = 1'b1;
        state_d       = bus.mem_resp ? FETCH3 : FETCH2;
      end
      FETCH3: begin
        ctrl.load_ir = 1'b1;
        state_d      = DECODE;
      end
      DECODE: begin
        md_issued_d = 1'b0;
        cause_d     = TC_ILLEGAL;
        state_d     = (op == OP_LOAD || is_store) ? CALC_ADDR :
                      (op == OP_REG && is_m) ? (ENABLE_M ? MD_WAIT : TRAP) :
                      legal ? EXEC : TRAP;
      end
      EXEC: begin
        retire              = 1'b1;
        ctrl.load_pc        = 1'b1;
        state_d             = FETCH1;
        ctrl.alumux1_sel    = (op == OP_AUIPC || op == OP_JAL || op == OP_BR) ? A1_PC_OUT : A1_RS1_OUT;
        ctrl.alumux2_sel    = (op == OP_LUI || op == OP_AUIPC) ? A2_U_IMM : op == OP_BR ? A2_B_IMM :
                              op == OP_JAL ? A2_J_IMM : op == OP_REG ? A2_RS2_OUT : A2_I_IMM;
        ctrl.aluop          = (op == OP_IMM || op == OP_REG) ? arith_op : ALU_ADD;
        ctrl.cmpmux_sel     = op == OP_IMM ? CMP_I_IMM : CMP_RS2_OUT;
        ctrl.cmpop          = op == OP_BR ? branch_funct3_t'(f3) : f3[0] ? BR_BLTU : BR_BLT;
        ctrl.pcmux_sel      = op == OP_JALR ? PC_ALU_MOD2 : (op == OP_JAL || (op == OP_BR && bus.br_en)) ? PC_ALU_OUT : PC_PLUS4;
        ctrl.load_regfile   = op != OP_BR;
        ctrl.regfilemux_sel = op == OP_LUI ? RF_U_IMM : (op == OP_JAL || op == OP_JALR) ? RF_PC_PLUS4 :
                              ((op == OP_IMM || op == OP_REG) && is_slt) ? RF_BR_EN : RF_ALU_OUT;
      end
      CALC_ADDR: begin
        ctrl.alumux2_sel = is_store ? A2_S_IMM : A2_I_IMM;
        if (misaligned(f3[1:0], bus.addr_lsb)) begin
          state_d = TRAP;
          cause_d = TC_MISALIGNED;
        end else begin
          ctrl.load_mar      = 1'b1;
          ctrl.marmux_sel    = MAR_ALU_OUT;
          ctrl.load_data_out = is_store;
          mask_d             = store_mask(f3[1:0], bus.addr_lsb);
          state_d            = is_store ? ST1 : LD1;
        end
      end
      LD1: begin
        mem_read = 1'b1;
        state_d  = bus.mem_resp ? LD2 : LD1;
      end
      LD2: begin
        ctrl.load_regfile   = 1'b1;
        ctrl.regfilemux_sel = f3 == 3'b000 ? RF_LB : f3 == 3'b001 ? RF_LH : f3 == 3'b100 ? RF_LBU : f3 == 3'b101 ? RF_LHU : RF_LW;
        ctrl.load_pc        = 1'b1;
        retire              = 1'b1;
        state_d             = FETCH1;
      end
      ST1: begin
        mem_write = 1'b1;
        byte_en   = mask_q;
        state_d   = bus.mem_resp ? ST2 : ST1;
      end
      ST2: begin
        ctrl.load_pc = 1'b1;
        retire       = 1'b1;
        state_d      = FETCH1;
      end
      MD_WAIT: begin
        md_start    = !md_issued_q;
        md_issued_d = 1'b1;
        if (bus.md_done) begin
          ctrl.load_regfile   = 1'b1;
          ctrl.regfilemux_sel = RF_MULDIV_OUT;
          ctrl.load_pc        = 1'b1;
          retire              = 1'b1;
          md_issued_d         = 1'b0;
          state_d             = FETCH1;
        end
      end
      TRAP: begin
        retire         = 1'b1;
        ctrl.load_pc   = 1'b1;
        ctrl.pcmux_sel = TRAP_EN ? PC_TRAP_VEC : PC_PLUS4;
        trap           = TRAP_EN;
        trap_cause     = TRAP_EN ? cause_q : TC_ILLEGAL;
        state_d        = FETCH1;
      end
      default: state_d = FETCH1;
    endcase
    if (timeout) begin
      state_d = TRAP;
      cause_d = TC_TIMEOUT;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FETCH1;
      mask_q      <= 4'b0000;
      md_issued_q <= 1'b0;
      cause_q     <= TC_ILLEGAL;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      md_issued_q <= md_issued_d;
      cause_q     <= cause_d;
    end
  end
  assign bus.ctrl            = ctrl;
  assign bus.mem_read        = mem_read;
  assign bus.mem_write       = mem_write;
  assign bus.mem_byte_enable = byte_en;
  assign bus.md_start        = md_start;
  assign bus.trap            = trap;
  assign bus.trap_cause      = trap_cause;
  assign bus.retire          = retire;
endmodule
